// File: rtl/ram_stream_reader_if.sv
// Signal bundle between ram_stream_reader, its single-port block RAM and the stream consumer.
// The master modport is the reader; the slave modport is the surrounding system.
interface ram_stream_reader_if #(
  parameter int blockLength     = 8,
  parameter int addressBitWidth = 11
);
  logic                       start;
  logic [addressBitWidth-1:0] baseAddress;
  logic [addressBitWidth:0]   length;
  logic                       busy;
  logic                       done;
  logic [addressBitWidth-1:0] ramAddress;
  logic                       ramWriteEnable;
  logic [blockLength-1:0]     ramDataOut;
  logic [blockLength-1:0]     outData;
  logic                       outValid;
  logic                       outReady;

  modport master (
    input  start, baseAddress, length, ramDataOut, outReady,
    output busy, done, ramAddress, ramWriteEnable, outData, outValid
  );

  modport slave (
    output start, baseAddress, length, ramDataOut, outReady,
    input  busy, done, ramAddress, ramWriteEnable, outData, outValid
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader: streams length consecutive words from a registered-output block RAM,
// starting at baseAddress and wrapping at memDepth, through a 2-entry output FIFO.
module ram_stream_reader #(
  parameter int blockLength     = 8,
  parameter int addressBitWidth = 11,
  parameter int memDepth        = 1444
) (
  input logic                clock,
  input logic                reset,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [addressBitWidth-1:0] ADDR_ZERO    = {addressBitWidth{1'b0}};
  localparam logic [addressBitWidth-1:0] ADDR_ONE     = {{(addressBitWidth-1){1'b0}}, 1'b1};
  localparam logic [addressBitWidth-1:0] LAST_ADDRESS = addressBitWidth'(memDepth - 1);
  localparam logic [addressBitWidth:0]   LEN_ZERO     = {(addressBitWidth+1){1'b0}};
  localparam logic [addressBitWidth:0]   LEN_ONE      = {{addressBitWidth{1'b0}}, 1'b1};
  localparam logic [blockLength-1:0]     DATA_ZERO    = {blockLength{1'b0}};

  state_t                     state_r;
  logic [addressBitWidth-1:0] next_address_r;
  logic [addressBitWidth-1:0] ram_address_r;
  logic [addressBitWidth:0]   remaining_r;
  logic                       pending_r;
  logic [blockLength-1:0]     fifo_head_r;
  logic [blockLength-1:0]     fifo_tail_r;
  logic [1:0]                 occupancy_r;
  logic                       out_valid_r;
  logic                       busy_r;
  logic                       done_r;

  logic                       pop_s;
  logic                       issue_s;
  logic                       drained_s;
  logic [2:0]                 demand_s;

  // Issue a read only when the FIFO can absorb it alongside the word already in flight.
  always_comb begin
    pop_s    = out_valid_r & bus.outReady;
    demand_s = {1'b0, occupancy_r} + {2'b00, pending_r} - {2'b00, pop_s};
    if ((state_r == READ) && (remaining_r != LEN_ZERO) && (demand_s <= 3'd1)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (issue_s) begin
      bus.ramAddress = next_address_r;
    end else begin
      bus.ramAddress = ram_address_r;
    end
    if (!pending_r && ((occupancy_r == 2'd0) || ((occupancy_r == 2'd1) && pop_s))) begin
      drained_s = 1'b1;
    end else begin
      drained_s = 1'b0;
    end
  end

  // Control FSM, address generation and the two-entry output FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      next_address_r <= ADDR_ZERO;
      ram_address_r  <= ADDR_ZERO;
      remaining_r    <= LEN_ZERO;
      pending_r      <= 1'b0;
      fifo_head_r    <= DATA_ZERO;
      fifo_tail_r    <= DATA_ZERO;
      occupancy_r    <= 2'd0;
      out_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      pending_r <= issue_s;
      if (issue_s) begin
        ram_address_r  <= next_address_r;
        remaining_r    <= remaining_r - LEN_ONE;
        next_address_r <= (next_address_r == LAST_ADDRESS) ? ADDR_ZERO : next_address_r + ADDR_ONE;
      end

      // The word read last cycle lands at the tail; the head is what the consumer sees.
      case ({pending_r, pop_s})
        2'b10: begin
          if (occupancy_r == 2'd0) begin
            fifo_head_r <= bus.ramDataOut;
          end else begin
            fifo_tail_r <= bus.ramDataOut;
          end
          occupancy_r <= occupancy_r + 2'd1;
          out_valid_r <= 1'b1;
        end
        2'b01: begin
          if (occupancy_r == 2'd2) begin
            fifo_head_r <= fifo_tail_r;
          end
          occupancy_r <= occupancy_r - 2'd1;
          out_valid_r <= (occupancy_r == 2'd2);
        end
        2'b11: begin
          if (occupancy_r == 2'd2) begin
            fifo_head_r <= fifo_tail_r;
            fifo_tail_r <= bus.ramDataOut;
          end else begin
            fifo_head_r <= bus.ramDataOut;
          end
        end
        default: begin
        end
      endcase

      case (state_r)
        IDLE: begin
          if (bus.start) begin
            next_address_r <= bus.baseAddress;
            remaining_r    <= bus.length;
            if (bus.length != LEN_ZERO) begin
              state_r <= READ;
              busy_r  <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue_s && (remaining_r == LEN_ONE)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.ramWriteEnable = 1'b0;
  assign bus.outData        = fifo_head_r;
  assign bus.outValid       = out_valid_r;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model with word i = i mod 256, a queue of expected
// stream words built from base/length, and directed scenarios with literal expectations.
module tb_ram_stream_reader;
  localparam int BL = 8;
  localparam int AW = 11;
  localparam int LW = AW + 1;
  localparam int MD = 1444;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  logic [BL-1:0] exp_q[$];

  always #5 clock = ~clock;

  ram_stream_reader_if #(.blockLength(BL), .addressBitWidth(AW)) bus ();

  ram_stream_reader #(.blockLength(BL), .addressBitWidth(AW), .memDepth(MD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Block RAM with registered read data
  always @(posedge clock) bus.ramDataOut <= bus.ramAddress[7:0];

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic start_burst(input int base, input int len, input bit accept);
    bus.start       = 1'b1;
    bus.baseAddress = AW'(base);
    bus.length      = LW'(len);
    if (accept) begin
      for (int i = 0; i < len; i++) exp_q.push_back(BL'(((base + i) % MD) % 256));
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got == 0; c++) begin
      @(negedge clock);
      if (bus.done) got = 1;
    end
    check(name, got, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  // Stream scoreboard: every visible word must be the next expected one, held while stalled
  initial begin
    logic          prev_stall;
    logic [BL-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        check("write_enable", int'(bus.ramWriteEnable), 0);
        if (prev_stall) begin
          check("stall_valid", int'(bus.outValid), 1);
          check("stall_data", int'(bus.outData), int'(prev_data));
        end
        if (bus.outValid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", int'(bus.outValid), 0);
          end else begin
            check("stream_data", int'(bus.outData), int'(exp_q[0]));
            if (bus.outReady) void'(exp_q.pop_front());
          end
        end
        prev_stall = bus.outValid && !bus.outReady;
        prev_data  = bus.outData;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int pops;
    int exp_addr[4];
    int exp_data[4];
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.baseAddress = '0;
    bus.length      = '0;
    bus.outReady    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_valid", int'(bus.outValid), 0);
    check("rst_addr", int'(bus.ramAddress), 0);
    check("rst_data", int'(bus.outData), 0);
    check("rst_wen", int'(bus.ramWriteEnable), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // base 5, length 4, consumer always ready
    start_burst(5, 4, 1'b1);
    @(negedge clock);
    check("b1_busy", int'(bus.busy), 1);
    check("b1_first_addr", int'(bus.ramAddress), 5);
    check("b1_valid_k1", int'(bus.outValid), 0);
    @(negedge clock);
    check("b1_valid_k2", int'(bus.outValid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("b1_valid", int'(bus.outValid), 1);
      check("b1_data", int'(bus.outData), 5 + i);
    end
    d = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.done) d++;
    end
    check("b1_done_count", d, 1);
    check("b1_idle", int'(bus.busy), 0);
    @(posedge clock); #1;

    // wrap at the end of memory
    exp_addr = '{1442, 1443, 0, 1};
    exp_data = '{162, 163, 0, 1};
    start_burst(1442, 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i < 4) check("wrap_addr", int'(bus.ramAddress), exp_addr[i]);
      if (i >= 2) check("wrap_data", int'(bus.outData), exp_data[i - 2]);
    end
    wait_done("wrap_done", 10);

    // zero-length burst
    start_burst(7, 0, 1'b1);
    @(negedge clock);
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    check("zero_valid", int'(bus.outValid), 0);
    d = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      d += int'(bus.done) + int'(bus.outValid) + int'(bus.busy);
    end
    check("zero_quiet", d, 0);
    @(posedge clock); #1;

    // consumer stalls with ready pattern 1,0,0,1
    start_burst(0, 6, 1'b1);
    d = 0;
    for (int c = 0; c < 80 && d == 0; c++) begin
      bus.outReady = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge clock);
      if (bus.done) d = 1;
      @(posedge clock); #1;
    end
    check("toggle_done", d, 1);
    check("toggle_drained", exp_q.size(), 0);
    bus.outReady = 1'b1;
    @(posedge clock); #1;

    // reset mid-burst after two words, together with a start that must lose to reset
    start_burst(20, 8, 1'b1);
    pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clock);
      if (bus.outValid && bus.outReady) pops++;
    end
    check("mid_pops", pops, 2);
    @(posedge clock); #1;
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.baseAddress = AW'(50);
    bus.length      = LW'(3);
    exp_q.delete();
    @(posedge clock); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    check("mid_valid", int'(bus.outValid), 0);
    check("mid_busy", int'(bus.busy), 0);
    check("mid_done", int'(bus.done), 0);
    d = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      d += int'(bus.done) + int'(bus.busy) + int'(bus.outValid);
    end
    check("mid_quiet", d, 0);
    @(posedge clock); #1;
    start_burst(10, 2, 1'b1);
    repeat (2) @(negedge clock);
    @(negedge clock);
    check("post_rst_w0", int'(bus.outData), 10);
    @(negedge clock);
    check("post_rst_w1", int'(bus.outData), 11);
    wait_done("post_rst_done", 10);

    // start pulsed again while busy is ignored
    start_burst(30, 5, 1'b1);
    @(posedge clock); #1;
    check("retrig_busy", int'(bus.busy), 1);
    start_burst(100, 3, 1'b0);
    wait_done("retrig_done", 30);
    d = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      d += int'(bus.done) + int'(bus.busy) + int'(bus.outValid);
    end
    check("retrig_quiet", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter blockLength, default 8, data word width in bits.
REQ-002 Parameter addressBitWidth, default 11, RAM address width.
REQ-003 Parameter memDepth, default 1444, number of RAM words; address wrap point.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-006 start  input  1  one-cycle request to begin a burst read; sampled only in IDLE.
REQ-007 baseAddress  input  addressBitWidth  first RAM word of burst; sampled with start; value < memDepth.
REQ-008 length  input  addressBitWidth+1  word count of burst; sampled with start; 0 legal.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse when burst complete.
REQ-011 ramAddress  output  addressBitWidth  address to single-port block RAM.
REQ-012 ramWriteEnable  output  1  RAM write enable; constant 0.
REQ-013 ramDataOut  input  blockLength  RAM registered read data; valid one cycle after ramAddress is presented.
REQ-014 outData  output  blockLength  stream data.
REQ-015 outValid  output  1  outData holds a valid word.
REQ-016 outReady  input  1  consumer accepts word when outValid && outReady at rising edge.

Function
REQ-017 Block SHALL have states IDLE, READ, DRAIN; done is a registered pulse issued on the DRAIN->IDLE transition.
REQ-018 IDLE: start=1 SHALL capture baseAddress/length into nextAddress/remaining and go to READ (length>0) or pulse done next cycle and stay IDLE (length=0).
REQ-019 start while busy SHALL be ignored, with no effect on the burst in progress.
REQ-020 Output buffer SHALL be a 2-entry FIFO; a one-bit pending flag SHALL mark that ramDataOut holds an issued read this cycle.
REQ-021 In READ, a read SHALL issue in a cycle iff remaining>0 and (occupancy + pending - pop) <= 1, with pop = outValid && outReady.
REQ-022 Issued read: ramAddress = nextAddress that cycle; at edge, remaining -= 1, pending <= 1, nextAddress advances.
REQ-023 nextAddress SHALL wrap from memDepth-1 to 0; no other wrap point.
REQ-024 Non-issue cycles: ramAddress SHALL hold last value; pending <= 0.
REQ-025 pending=1 at an edge SHALL write ramDataOut into FIFO tail; simultaneous push and pop SHALL keep occupancy constant and preserve order.
REQ-026 outValid = (occupancy>0); outData = FIFO head; outData SHALL remain stable while outValid && !outReady.
REQ-027 Latency: start accepted at edge k -> first ramAddress in cycle after k -> outValid high after edge k+2.
REQ-028 With outReady held 1, throughput SHALL be one word per cycle with no bubbles after the first.
REQ-029 READ -> DRAIN when remaining reaches 0; DRAIN -> IDLE with done=1 in the cycle after the last word is popped and pending=0.
REQ-030 Words SHALL be emitted exactly once, in address order, count equal to length.
REQ-031 Issue logic SHALL never push when occupancy=2; FIFO overflow is impossible by construction.

Reset
REQ-032 reset=1 at any edge, including mid-burst, SHALL force IDLE, flush the FIFO, and clear pending and remaining.
REQ-033 After reset: busy=0, done=0, outValid=0, ramAddress=0, outData=0, ramWriteEnable=0.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 RAM word i = i mod 256; start, base=5, length=4, outReady=1 -> outData 5,6,7,8 on consecutive cycles; outValid first high 2 cycles after start; done pulses once.
REQ-036 base=1442, length=4 -> addresses 1442,1443,0,1; outData 0xA2,0xA3,0x00,0x01.
REQ-037 length=0 -> done pulses the cycle after start; outValid never rises; busy stays 0.
REQ-038 base=0, length=6, outReady toggling 1,0,0,1,... -> all 6 words (0..5) in order; head stable while stalled; occupancy never exceeds 2.
REQ-039 reset asserted after 2 of 8 words accepted -> next cycle outValid=0, busy=0, no done; a new start, base=10, length=2 -> outData 10, 11.
REQ-040 start re-pulsed while busy with base=100 -> ignored; original burst completes unchanged.
